// File: rtl/alu_seq_mc.sv
// Sequential signed ALU: ADD/SUB/MULT finish one cycle after acceptance,
// DIV runs a WIDTH-cycle restoring divide on operand magnitudes.
module alu_seq_mc #(
  parameter int unsigned WIDTH  = 8,
  parameter bit          SAT_EN = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] operand1,
  input  logic signed [WIDTH-1:0] operand2,
  input  logic        [1:0]       opcode,
  output logic signed [WIDTH-1:0] out,
  output logic                    out_valid,
  output logic                    ovf,
  output logic                    dz
);
  localparam int unsigned       CW      = $clog2(WIDTH);
  localparam logic [CW-1:0]     LAST    = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0]  MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]  MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {IDLE, DIVIDE} state_t;
  state_t state, state_nx;

  logic                    accept, div_start;
  logic [CW-1:0]           cnt;
  logic [WIDTH-1:0]        rem, quo, dvsr;
  logic                    q_neg;
  logic [WIDTH-1:0]        op1_mag, op2_mag;
  logic [WIDTH:0]          rem_sh, rem_diff;
  logic                    rem_ge;
  logic [WIDTH-1:0]        rem_nx, quo_nx, quo_signed;
  logic                    div_ovf;
  logic signed [WIDTH:0]   sum_x;
  logic signed [2*WIDTH-1:0] op1_x, op2_x, prod;
  logic [WIDTH-1:0]        imm_res, imm_out;
  logic                    imm_ovf, imm_dz, imm_neg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (div_start) state_nx = DIVIDE;
      DIVIDE: if (cnt == LAST) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready = rst && (state == IDLE);
  end

  assign accept    = in_valid && in_ready;
  assign div_start = accept && (opcode == 2'b11) && (|operand2);

  assign op1_mag = operand1[WIDTH-1] ? -operand1 : operand1;
  assign op2_mag = operand2[WIDTH-1] ? -operand2 : operand2;

  // rem < dvsr always holds, so the (WIDTH+1)-bit difference never wraps
  // and its top bit is a reliable "trial subtraction failed" flag.
  assign rem_sh     = {rem, quo[WIDTH-1]};
  assign rem_diff   = rem_sh - {1'b0, dvsr};
  assign rem_ge     = ~rem_diff[WIDTH];
  assign rem_nx     = rem_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quo_nx     = {quo[WIDTH-2:0], rem_ge};
  assign quo_signed = q_neg ? -quo_nx : quo_nx;
  assign div_ovf    = !q_neg && quo_nx[WIDTH-1];

  assign op1_x = {{WIDTH{operand1[WIDTH-1]}}, operand1};
  assign op2_x = {{WIDTH{operand2[WIDTH-1]}}, operand2};
  assign prod  = op1_x * op2_x;

  always_comb begin
    sum_x   = '0;
    imm_res = '0;
    imm_ovf = 1'b0;
    imm_dz  = 1'b0;
    imm_neg = 1'b0;
    unique case (opcode)
      2'b00: begin
        sum_x   = {operand1[WIDTH-1], operand1} + {operand2[WIDTH-1], operand2};
        imm_res = sum_x[WIDTH-1:0];
        imm_ovf = sum_x[WIDTH] ^ sum_x[WIDTH-1];
        imm_neg = sum_x[WIDTH];
      end
      2'b01: begin
        sum_x   = {operand1[WIDTH-1], operand1} - {operand2[WIDTH-1], operand2};
        imm_res = sum_x[WIDTH-1:0];
        imm_ovf = sum_x[WIDTH] ^ sum_x[WIDTH-1];
        imm_neg = sum_x[WIDTH];
      end
      2'b10: begin
        imm_res = prod[WIDTH-1:0];
        imm_ovf = ~((&prod[2*WIDTH-1:WIDTH-1]) | ~(|prod[2*WIDTH-1:WIDTH-1]));
        imm_neg = prod[2*WIDTH-1];
      end
      default: imm_dz = 1'b1;
    endcase
    imm_out = (SAT_EN && imm_ovf) ? (imm_neg ? MIN_NEG : MAX_POS) : imm_res;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out       <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
      dz        <= 1'b0;
      cnt       <= '0;
      rem       <= '0;
      quo       <= '0;
      dvsr      <= '0;
      q_neg     <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (state == IDLE) begin
        if (div_start) begin
          cnt   <= '0;
          rem   <= '0;
          quo   <= op1_mag;
          dvsr  <= op2_mag;
          q_neg <= operand1[WIDTH-1] ^ operand2[WIDTH-1];
        end else if (accept) begin
          out       <= imm_out;
          ovf       <= imm_ovf;
          dz        <= imm_dz;
          out_valid <= 1'b1;
        end
      end else begin
        cnt <= cnt + 1'b1;
        rem <= rem_nx;
        quo <= quo_nx;
        if (cnt == LAST) begin
          out       <= (SAT_EN && div_ovf) ? MAX_POS : quo_signed;
          ovf       <= div_ovf;
          dz        <= 1'b0;
          out_valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_seq_mc.sv
// Bench for alu_seq_mc: three instances (8-bit wrap, 8-bit saturate, 16-bit wrap)
// share stimulus; a per-instance scoreboard with due cycles checks every cycle.
module tb_alu_seq_mc;
  typedef struct {
    longint due;
    longint r;
    bit     o;
    bit     d;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, in_valid;
  logic [1:0]        opcode;
  logic signed [7:0] a8, b8;
  logic signed [15:0] a16, b16;
  logic              rdy0, rdy1, rdy2, ov0, ov1, ov2, ovf0, ovf1, ovf2, dz0, dz1, dz2;
  logic signed [7:0] out0, out1;
  logic signed [15:0] out2;

  int     total = 0;
  int     bad   = 0;
  longint cyc   = 0;
  exp_t   sb [3][$];
  int     busy [3];
  bit     acc [3];
  bit     accdiv [3];
  longint last_r [3];
  bit     last_o [3];
  bit     last_d [3];

  alu_seq_mc #(.WIDTH(8), .SAT_EN(1'b0)) dut_w8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
    .operand1(a8), .operand2(b8), .opcode(opcode),
    .out(out0), .out_valid(ov0), .ovf(ovf0), .dz(dz0));

  alu_seq_mc #(.WIDTH(8), .SAT_EN(1'b1)) dut_w8s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
    .operand1(a8), .operand2(b8), .opcode(opcode),
    .out(out1), .out_valid(ov1), .ovf(ovf1), .dz(dz1));

  alu_seq_mc #(.WIDTH(16), .SAT_EN(1'b0)) dut_w16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2),
    .operand1(a16), .operand2(b16), .opcode(opcode),
    .out(out2), .out_valid(ov2), .ovf(ovf2), .dz(dz2));

  task automatic chk(input int k, input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL dut%0d %s: got %0d want %0d", k, tag, obs, exp);
    end
  endtask

  function automatic void model(input int w, input bit sat, input logic [1:0] op,
                                input longint a, input longint b,
                                output longint r, output bit o, output bit d);
    longint e, mx, mn;
    mx = (longint'(1) << (w - 1)) - 1;
    mn = -(longint'(1) << (w - 1));
    e = 0;
    d = 1'b0;
    case (op)
      2'b00: e = a + b;
      2'b01: e = a - b;
      2'b10: e = a * b;
      default: if (b == 0) d = 1'b1; else e = a / b;
    endcase
    o = (e > mx) || (e < mn);
    if (!o) r = e;
    else if (sat) r = (e > 0) ? mx : mn;
    else begin
      r = e & ((longint'(1) << w) - 1);
      if (r > mx) r = r - (longint'(1) << w);
    end
  endfunction

  task automatic reset_model();
    for (int k = 0; k < 3; k++) begin
      sb[k].delete();
      busy[k]   = 0;
      acc[k]    = 1'b0;
      accdiv[k] = 1'b0;
      last_r[k] = 0;
      last_o[k] = 1'b0;
      last_d[k] = 1'b0;
    end
  endtask

  task automatic check_dut(input int k, input int w, input bit sat, input logic rdy,
                           input logic ov, input logic signed [63:0] o, input logic of,
                           input logic d, input longint a, input longint b);
    exp_t e;
    bit   due;
    due = (sb[k].size() > 0) && (sb[k][0].due == cyc);
    chk(k, "in_ready", 64'(rdy), 64'(rst && busy[k] == 0));
    chk(k, "out_valid", 64'(ov), 64'(due));
    if (due) begin
      e = sb[k].pop_front();
      last_r[k] = e.r;
      last_o[k] = e.o;
      last_d[k] = e.d;
    end
    chk(k, "out", o, last_r[k]);
    chk(k, "ovf", 64'(of), 64'(last_o[k]));
    chk(k, "dz", 64'(d), 64'(last_d[k]));
    acc[k]    = in_valid && rst && (busy[k] == 0);
    accdiv[k] = acc[k] && (opcode == 2'b11) && (b != 0);
    if (acc[k]) begin
      model(w, sat, opcode, a, b, e.r, e.o, e.d);
      e.due = cyc + 1 + (accdiv[k] ? w : 0);
      sb[k].push_back(e);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_dut(0, 8, 1'b0, rdy0, ov0, out0, ovf0, dz0, a8, b8);
    check_dut(1, 8, 1'b1, rdy1, ov1, out1, ovf1, dz1, a8, b8);
    check_dut(2, 16, 1'b0, rdy2, ov2, out2, ovf2, dz2, a16, b16);
    @(posedge clk);
    cyc++;
    for (int k = 0; k < 3; k++) begin
      if (accdiv[k]) busy[k] = (k == 2) ? 16 : 8;
      else if (busy[k] > 0) busy[k]--;
    end
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic op(input logic [1:0] opc, input longint x, input longint y);
    in_valid = 1'b1;
    opcode   = opc;
    a8  = x[7:0];
    b8  = y[7:0];
    a16 = x[15:0];
    b16 = y[15:0];
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    int r;
    rst = 1'b0;
    in_valid = 1'b0;
    opcode = 2'b00;
    a8 = '0; b8 = '0; a16 = '0; b16 = '0;
    reset_model();
    idle(2);
    chk(0, "rst_ready", 64'(rdy0), 0);
    chk(0, "rst_out", out0, 0);
    rst = 1'b1;
    idle(1);

    op(2'b00, 100, 50);
    chk(0, "add_wrap", out0, -106);
    chk(0, "add_ovf", 64'(ovf0), 1);
    chk(1, "add_sat", out1, 127);
    chk(2, "add_w16", out2, 150);
    op(2'b10, -16, 8);
    chk(0, "mul_neg", out0, -128);
    chk(0, "mul_neg_ovf", 64'(ovf0), 0);
    op(2'b10, 16, 8);
    chk(0, "mul_wrap", out0, -128);
    chk(1, "mul_sat", out1, 127);
    op(2'b01, -128, 1);
    chk(0, "sub_wrap", out0, 127);
    chk(1, "sub_sat", out1, -128);
    idle(1);

    op(2'b11, -7, 2);
    idle(7);
    chk(0, "div_busy", 64'(rdy0), 0);
    idle(1);
    chk(0, "div_m7_2", out0, -3);
    chk(0, "div_valid", 64'(ov0), 1);
    idle(8);
    op(2'b11, 7, -2);
    idle(16);
    chk(0, "div_7_m2", out0, -3);
    op(2'b11, -128, -1);
    idle(16);
    chk(0, "div_min_wrap", out0, -128);
    chk(0, "div_min_ovf", 64'(ovf0), 1);
    chk(1, "div_min_sat", out1, 127);

    op(2'b11, 5, 0);
    chk(0, "dz_flag", 64'(dz0), 1);
    chk(0, "dz_out", out0, 0);
    chk(0, "dz_ready", 64'(rdy0), 1);
    idle(1);

    op(2'b11, 100, 3);
    idle(3);
    rst = 1'b0;
    #1;
    chk(0, "abort_out", out0, 0);
    chk(0, "abort_ready", 64'(rdy0), 0);
    reset_model();
    idle(2);
    rst = 1'b1;
    idle(1);
    op(2'b00, 3, 4);
    chk(0, "post_rst_add", out0, 7);
    idle(2);

    // Operands keep changing while a divide is in flight; the model ignores them.
    in_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      r = int'($urandom_range(0, 15));
      opcode = 2'($urandom_range(0, 3));
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      if (r == 0) begin
        b8 = '0; b16 = '0;
      end else if (r == 1) begin
        a8 = 8'h80; b8 = 8'hff; a16 = 16'h8000; b16 = 16'hffff;
      end else if (r < 6) begin
        b8  = 8'($urandom_range(1, 7));
        b16 = 16'($urandom_range(1, 300));
      end
      tick();
    end
    idle(20);
    for (int k = 0; k < 3; k++) chk(k, "drain", 64'(sb[k].size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
